// File: rtl/instr_decoder_pkg.sv
// Shared definitions for the SPI command/data frame decoder.
package instr_decoder_pkg;

    typedef enum logic [1:0] {
        S_CMD  = 2'd0,
        S_RD   = 2'd1,
        S_DATA = 2'd2
    } state_t;

    // Position of the read/write flag inside the command byte.
    localparam int RW_BIT = 7;

    localparam logic CMD_WRITE = 1'b1;
    localparam logic CMD_READ  = 1'b0;

endpackage

// File: rtl/instr_decoder.sv
// Two-byte SPI frame decoder: command byte (rw + address) followed by a data
// byte, producing single-cycle register-file read/write strobes.
//
// state  | meaning
// S_CMD  | waiting for a command byte
// S_RD   | read strobe cycle, register-file data captured into data_out
// S_DATA | waiting for the data byte (write payload, or discarded on a read)
module instr_decoder
    import instr_decoder_pkg::*;
#(
    parameter int          ADDR_W     = 6,
    parameter logic [7:0]  RD_DEFAULT = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              byte_sync,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        data_write,
    input  logic [7:0]        data_read
);

    state_t              state_q, state_d;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                read_q, read_d;
    logic                write_q, write_d;
    logic [7:0]          data_write_q, data_write_d;
    logic [7:0]          data_out_q, data_out_d;

    // Next-state and registered-output decode; strobes are computed one cycle
    // early so every output comes straight from a flop.
    always_comb begin
        state_d      = state_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        read_d       = 1'b0;
        write_d      = 1'b0;
        data_write_d = data_write_q;
        data_out_d   = data_out_q;

        case (state_q)
            S_CMD: begin
                if (byte_sync) begin
                    rw_d   = data_in[RW_BIT];
                    addr_d = data_in[ADDR_W-1:0];
                    if (data_in[RW_BIT] == CMD_WRITE) begin
                        state_d = S_DATA;
                    end else begin
                        state_d = S_RD;
                        read_d  = 1'b1;
                    end
                end
            end
            S_RD: begin
                // byte_sync cannot legally arrive here and is ignored.
                data_out_d = data_read;
                state_d    = S_DATA;
            end
            S_DATA: begin
                if (byte_sync) begin
                    state_d = S_CMD;
                    if (rw_q == CMD_WRITE) begin
                        write_d      = 1'b1;
                        data_write_d = data_in;
                    end else begin
                        data_out_d = RD_DEFAULT;
                    end
                end
            end
            default: begin
                state_d = S_CMD;
            end
        endcase
    end

    // State and output registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_CMD;
            rw_q         <= CMD_READ;
            addr_q       <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            data_write_q <= 8'h00;
            data_out_q   <= RD_DEFAULT;
        end else begin
            state_q      <= state_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            read_q       <= read_d;
            write_q      <= write_d;
            data_write_q <= data_write_d;
            data_out_q   <= data_out_d;
        end
    end

    assign data_out   = data_out_q;
    assign read       = read_q;
    assign write      = write_q;
    assign addr       = addr_q;
    assign data_write = data_write_q;

endmodule

// File: tb/tb_instr_decoder.sv
// Directed bench for instr_decoder with a strobe scoreboard and a simple
// register-file model answering read strobes.
module tb_instr_decoder;

    localparam int         ADDR_W     = 6;
    localparam logic [7:0] RD_DEFAULT = 8'h00;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              byte_sync = 1'b0;
    logic [7:0]        data_in = 8'h00;
    logic [7:0]        data_out;
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data_write;
    logic [7:0]        data_read;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       is_wr;
        logic [5:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] shadow [64];
    logic [7:0] mem [64];

    instr_decoder #(.ADDR_W(ADDR_W), .RD_DEFAULT(RD_DEFAULT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_sync  (byte_sync),
        .data_in    (data_in),
        .data_out   (data_out),
        .read       (read),
        .write      (write),
        .addr       (addr),
        .data_write (data_write),
        .data_read  (data_read)
    );

    always #5 clk = ~clk;

    // Register-file model driven by the DUT strobes.
    always @(posedge clk) begin
        if (write) mem[addr] <= data_write;
    end
    assign data_read = mem[addr];

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic expect_write(input logic [5:0] a, input logic [7:0] d);
        exp_t e;
        e.is_wr = 1'b1; e.addr = a; e.data = d;
        sb.push_back(e);
        shadow[a] = d;
    endtask

    task automatic expect_read(input logic [5:0] a);
        exp_t e;
        e.is_wr = 1'b0; e.addr = a; e.data = shadow[a];
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; leaves the bench at the negedge after the capture edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        byte_sync = 1'b1;
        data_in   = b;
        @(negedge clk);
        byte_sync = 1'b0;
        data_in   = 8'($urandom);
        idle(gap);
    endtask

    task automatic wr_frame(input logic [7:0] cmd, input logic [7:0] d);
        expect_write(cmd[5:0], d);
        send_byte(cmd, 3);
        send_byte(d, 0);
        check8("wr_latency", {7'b0, write}, 8'h01);
        check8("wr_addr", {2'b0, addr}, {2'b0, cmd[5:0]});
        check8("wr_data_direct", data_write, d);
        idle(3);
    endtask

    // Strobe monitor: overlap, width and scoreboard ordering.
    logic       prev_read = 1'b0;
    logic       prev_write = 1'b0;
    logic       rd_pend = 1'b0;
    logic [7:0] rd_exp = 8'h00;
    always @(negedge clk) begin
        exp_t item;
        if (rd_pend) begin
            rd_pend = 1'b0;
            check8("rd_capture", data_out, rd_exp);
        end
        if (read || write) begin
            check8("strobe_overlap", {7'b0, read & write}, 8'h00);
            check8("strobe_width", {6'b0, read & prev_read, write & prev_write}, 8'h00);
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_strobe observed read=%0b write=%0b addr=%02h expected none", read, write, addr);
            end
            if (sb.size() != 0) begin
                item = sb.pop_front();
                check8("strobe_kind", {7'b0, write}, {7'b0, item.is_wr});
                check8("strobe_addr", {2'b0, addr}, {2'b0, item.addr});
                if (item.is_wr) check8("sb_wr_data", data_write, item.data);
                else begin
                    rd_pend = 1'b1;
                    rd_exp  = item.data;
                end
            end
        end
        prev_read  = read;
        prev_write = write;
    end

    initial begin
        for (int i = 0; i < 64; i++) shadow[i] = 8'h00;

        // Reset state
        idle(3);
        check8("rst_read", {7'b0, read}, 8'h00);
        check8("rst_write", {7'b0, write}, 8'h00);
        check8("rst_addr", {2'b0, addr}, 8'h00);
        check8("rst_data_write", data_write, 8'h00);
        check8("rst_data_out", data_out, RD_DEFAULT);
        rst_n = 1'b1;
        idle(2);

        // Basic write
        wr_frame(8'h85, 8'hA5);

        // Basic read of a preloaded register
        wr_frame(8'h8A, 8'h3C);
        expect_read(6'h0A);
        send_byte(8'h0A, 0);
        check8("rd_latency", {7'b0, read}, 8'h01);
        check8("rd_addr", {2'b0, addr}, 8'h0A);
        check8("rd_data_not_yet", data_out, 8'h00);
        idle(1);
        check8("rd_single", {7'b0, read}, 8'h00);
        check8("rd_data_out", data_out, 8'h3C);
        idle(3);
        send_byte(8'h5B, 0);
        check8("rd_default", data_out, RD_DEFAULT);
        idle(3);

        // Reserved bit ignored, top of address range
        wr_frame(8'hFF, 8'h77);
        wr_frame(8'hC5, 8'h11);

        // Back-to-back: read command arrives in the write strobe cycle
        expect_write(6'h01, 8'h5A);
        send_byte(8'h81, 3);
        send_byte(8'h5A, 0);
        check8("b2b_write", {7'b0, write}, 8'h01);
        expect_read(6'h01);
        send_byte(8'h01, 0);
        check8("b2b_read", {7'b0, read}, 8'h01);
        check8("b2b_addr", {2'b0, addr}, 8'h01);
        idle(1);
        check8("b2b_data", data_out, 8'h5A);
        idle(3);
        send_byte(8'hE7, 0);
        check8("b2b_default", data_out, RD_DEFAULT);
        idle(3);

        // byte_sync during the read strobe cycle is ignored
        expect_read(6'h3F);
        send_byte(8'h3F, 0);
        send_byte(8'h85, 0);
        check8("srd_ignore_data", data_out, 8'h77);
        check8("srd_ignore_write", {7'b0, write}, 8'h00);
        send_byte(8'h44, 2);
        check8("srd_default", data_out, RD_DEFAULT);
        wr_frame(8'h86, 8'h21);

        // Reset with a captured value in data_out
        wr_frame(8'h82, 8'hC3);
        expect_read(6'h02);
        send_byte(8'h02, 1);
        check8("pre_rst_data", data_out, 8'hC3);
        #1 rst_n = 1'b0;
        #1;
        check8("async_rst_data_out", data_out, RD_DEFAULT);
        check8("async_rst_addr", {2'b0, addr}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Reset mid-frame after a write command
        send_byte(8'h90, 3);
        #1 rst_n = 1'b0;
        #1;
        check8("midrst_addr", {2'b0, addr}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        expect_read(6'h02);
        send_byte(8'h02, 0);
        check8("midrst_read", {7'b0, read}, 8'h01);
        check8("midrst_addr2", {2'b0, addr}, 8'h02);
        idle(1);
        check8("midrst_data", data_out, 8'hC3);
        idle(3);
        send_byte(8'h11, 0);
        check8("midrst_no_write", {7'b0, write}, 8'h00);
        check8("midrst_default", data_out, RD_DEFAULT);
        idle(3);

        // Idle noise
        for (int i = 0; i < 1000; i++) begin
            data_in = 8'($urandom);
            @(negedge clk);
            check8("idle_strobes", {6'b0, read, write}, 8'h00);
            check8("idle_data_out", data_out, RD_DEFAULT);
        end

        // Still alive after the noise
        wr_frame(8'h9E, 8'h6D);
        expect_read(6'h1E);
        send_byte(8'h1E, 4);
        check8("final_read_data", data_out, 8'h6D);
        send_byte(8'h00, 3);

        check8("sb_empty", 8'(sb.size()), 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
